// File: rtl/rv32i_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu_pkg
// Purpose  : Shared types, byte-enable constants and helper functions for
//            the RV32I load/store unit and its load aligner.
// Contents : RV32I_INSTRUCTION_MNEMONIC_t, lsu_state_t, BE_* constants,
//            is_mem_op / is_store / is_half / is_word / lsu_be / lsu_wdata.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_lsu_pkg;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR, BEQ, BNE,
        ADDI, ADD, SUB, AND, OR, XOR,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        INVALID
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_REQ   = 2'd1,
        LSU_DONE  = 2'd2,
        LSU_FAULT = 2'd3
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    function automatic logic is_store(input RV32I_INSTRUCTION_MNEMONIC_t m);
        return (m == SB) || (m == SH) || (m == SW);
    endfunction

    function automatic logic is_mem_op(input RV32I_INSTRUCTION_MNEMONIC_t m);
        return (m == LB) || (m == LH) || (m == LW) || (m == LBU) ||
               (m == LHU) || is_store(m);
    endfunction

    function automatic logic is_half(input RV32I_INSTRUCTION_MNEMONIC_t m);
        return (m == LH) || (m == LHU) || (m == SH);
    endfunction

    function automatic logic is_word(input RV32I_INSTRUCTION_MNEMONIC_t m);
        return (m == LW) || (m == SW);
    endfunction

    function automatic logic [3:0] lsu_be(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                          input logic [1:0] lo);
        logic [3:0] be;
        if (is_word(m)) begin
            be = BE_WORD;
        end else if (is_half(m)) begin
            be = lo[1] ? BE_HALF1 : BE_HALF0;
        end else begin
            case (lo)
                2'd0:    be = BE_BYTE0;
                2'd1:    be = BE_BYTE1;
                2'd2:    be = BE_BYTE2;
                default: be = BE_BYTE3;
            endcase
        end
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone select it.
    function automatic logic [31:0] lsu_wdata(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                              input logic [31:0] d);
        logic [31:0] w;
        if (is_word(m)) begin
            w = d;
        end else if (is_half(m)) begin
            w = {2{d[15:0]}};
        end else begin
            w = {4{d[7:0]}};
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu_if
// Purpose  : Data-memory request/acknowledge port of the load/store unit.
// Ports    : mem_req, mem_we, mem_addr, mem_wdata, mem_be (master -> slave)
//            mem_ack, mem_rdata                           (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface rv32i_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_load_align.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_load_align
// Purpose  : Combinational load-data aligner: picks the addressed byte or
//            halfword from a 32-bit read word and sign/zero extends it.
// Ports    : rdata (32) in, addr_lo (2) in, mnemonic in, load_data (32) out
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_load_align
    import rv32i_lsu_pkg::*;
(
    input  wire logic [31:0]                rdata,
    input  wire logic [1:0]                 addr_lo,
    input  wire RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    output logic [31:0]                     load_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (mnemonic)
            LB:      load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     load_data = {24'd0, w_byte};
            LH:      load_data = {{16{w_half[15]}}, w_half};
            LHU:     load_data = {16'd0, w_half};
            default: load_data = rdata;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/rv32i_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu
// Purpose  : RV32I load/store unit. Registers a memory instruction, runs one
//            req/ack transaction on the data port, returns extended load data
//            and flags misaligned accesses and bus timeouts.
// Ports    : clk, rst (async, active-high)
//            start, mnemonic, addr, store_data          - from execute
//            busy, done, load_data, misaligned, bus_error - to core/writeback
//            bus (rv32i_lsu_if.master)                    - data memory
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        start,
    input  wire RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    input  wire logic [31:0]                 addr,
    input  wire logic [31:0]                 store_data,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      load_data,
    output logic                             misaligned,
    output logic                             bus_error,
    rv32i_lsu_if.master                      bus
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t                  state_q, state_d;
    RV32I_INSTRUCTION_MNEMONIC_t op_q, op_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 sdata_q, sdata_d;
    logic [31:0]                 load_data_q, load_data_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        mis_q, mis_d;
    logic                        berr_q, berr_d;

    logic                        w_misaligned;
    logic                        w_in_req;
    logic [31:0]                 w_aligned;

    assign w_misaligned = (is_half(mnemonic) && addr[0]) ||
                          (is_word(mnemonic) && (addr[1:0] != 2'b00));

    rv32i_load_align u_align (
        .rdata     (bus.mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .mnemonic  (op_q),
        .load_data (w_aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            op_q        <= ADD;
            addr_q      <= 32'd0;
            sdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            cnt_q       <= 8'd0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        mis_d       = mis_q;
        berr_d      = berr_q;

        case (state_q)
            LSU_IDLE: begin
                if (start && is_mem_op(mnemonic)) begin
                    op_d    = mnemonic;
                    addr_d  = addr;
                    sdata_d = store_data;
                    cnt_d   = 8'd0;
                    berr_d  = 1'b0;
                    mis_d   = w_misaligned;
                    if (w_misaligned) begin
                        load_data_d = 32'd0;
                        state_d     = LSU_FAULT;
                    end else begin
                        state_d     = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                // Ack takes priority over the timeout on the same edge.
                if (bus.mem_ack) begin
                    if (!is_store(op_q)) begin
                        load_data_d = w_aligned;
                    end
                    state_d = LSU_DONE;
                end else if (cnt_q == TO_LAST) begin
                    berr_d      = 1'b1;
                    load_data_d = 32'd0;
                    state_d     = LSU_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LSU_DONE, LSU_FAULT: begin
                mis_d   = 1'b0;
                berr_d  = 1'b0;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Bus outputs are decoded from state so reset removes mem_req at once.
    assign w_in_req      = (state_q == LSU_REQ);
    assign busy          = (state_q != LSU_IDLE);
    assign done          = (state_q == LSU_DONE) || (state_q == LSU_FAULT);
    assign misaligned    = (state_q == LSU_FAULT) && mis_q;
    assign bus_error     = (state_q == LSU_FAULT) && berr_q;
    assign load_data     = load_data_q;

    assign bus.mem_req   = w_in_req;
    assign bus.mem_we    = w_in_req && is_store(op_q);
    assign bus.mem_addr  = w_in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.mem_be    = w_in_req ? lsu_be(op_q, addr_q[1:0]) : 4'd0;
    assign bus.mem_wdata = w_in_req ? lsu_wdata(op_q, sdata_q) : 32'd0;
endmodule
`default_nettype wire
